// File: rtl/my_uart_rx.sv
// UART receiver: 8 data bits LSB first, 1 stop bit, 3-sample majority at mid-bit.
// Define UART_RX_PARITY_EN to add an even-parity bit and drive parity_err.
module my_uart_rx #(
    parameter int unsigned CLK_FREQ = 25000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);
    localparam int unsigned BIT_CNT = CLK_FREQ / BAUD;
    localparam int unsigned HALF    = BIT_CNT / 2;
    localparam int unsigned CW      = $clog2(BIT_CNT);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q, edge_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            s0_q, s0_d, s1_q, s1_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            int_q, int_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            pmis_q, pmis_d;
    logic            perr_q, perr_d;
`endif

    logic start_edge, decide, maj;

    assign start_edge = edge_q & ~sync2_q;
    assign decide     = (state_q != IDLE) && (cnt_q == CW'(HALF + 1));
    // Third vote is the live synced value at the decision clock.
    assign maj        = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start_edge) state_d = START;
            START:  if (decide) state_d = maj ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (decide && bit_idx_q == 3'd7) state_d = PARITY;
            PARITY: if (decide) state_d = STOP;
`else
            DATA:   if (decide && bit_idx_q == 3'd7) state_d = STOP;
`endif
            STOP:   if (decide) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_busy   = (state_q != IDLE);
        rx_data   = data_q;
        rx_int    = int_q;
        frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
        parity_err = perr_q;
`else
        parity_err = 1'b0;
`endif
    end

    always_comb begin
        cnt_d     = '0;
        s0_d      = s0_q;
        s1_d      = s1_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        int_d     = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        pmis_d    = pmis_q;
        perr_d    = 1'b0;
`endif
        if (state_q != IDLE) begin
            cnt_d = (cnt_q == CW'(BIT_CNT - 1)) ? '0 : cnt_q + CW'(1);
        end
        if (cnt_q == CW'(HALF - 1)) s0_d = sync2_q;
        if (cnt_q == CW'(HALF))     s1_d = sync2_q;
        if (decide) begin
            case (state_q)
                START: begin
                    bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                    pmis_d    = 1'b0;
`endif
                end
                DATA: begin
                    shift_d   = {maj, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: pmis_d = maj ^ (^shift_q);
                STOP: begin
                    ferr_d = ~maj;
                    perr_d = pmis_q;
                    if (maj && !pmis_q) begin
                        data_d = shift_q;
                        int_d  = 1'b1;
                    end
                end
`else
                STOP: begin
                    ferr_d = ~maj;
                    if (maj) begin
                        data_d = shift_q;
                        int_d  = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            edge_q    <= 1'b1;
            cnt_q     <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            int_q     <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pmis_q    <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync1_q   <= uart_rx;
            sync2_q   <= sync1_q;
            edge_q    <= sync2_q;
            cnt_q     <= cnt_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            int_q     <= int_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            pmis_q    <= pmis_d;
            perr_q    <= perr_d;
`endif
        end
    end

endmodule
